// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width and the idle (null) flit encoding.
package noc_pkg;
    localparam int              FLIT_W    = 20;
    localparam logic [FLIT_W-1:0] NULL_FLIT = '0;
endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with registered occupancy; storage is not reset.
module flit_fifo
    import noc_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] wdata,
    output logic [FLIT_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    // Pointers are exactly AW bits, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
            if (push && !pop)      r_count <= r_count + 1'b1;
            else if (pop && !push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= wdata;
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
endmodule

// File: rtl/ni_inject_buf.sv
// Network-interface injection buffer: null filter, overflow drop counter,
// credit-gated drain of a flit FIFO into a registered router port.
module ni_inject_buf
    import noc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CREDITS    = 4,
    parameter int DROP_NULL  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              credit_in,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [7:0]        drop_count,
    output logic              credit_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0]     r_credit;
    logic [7:0]        r_drop;
    logic              r_cerr;
    logic [FLIT_W-1:0] r_odata;
    logic              r_ovalid;

    logic [FLIT_W-1:0] w_rdata;
    logic [AW:0]       w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_live;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_live = in_valid && !((DROP_NULL != 0) && (in_data == NULL_FLIT));
    assign w_pop  = (w_count != '0) && (r_credit != '0);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push = w_live && (!w_full || w_pop);
    assign w_drop = w_live && w_full && !w_pop;

    flit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit <= CW'(CREDITS);
            r_cerr   <= 1'b0;
        end else if (w_pop && !credit_in) begin
            r_credit <= r_credit - 1'b1;
        end else if (!w_pop && credit_in) begin
            // A credit beyond the maximum is a protocol error, never counted.
            if (r_credit == CW'(CREDITS)) r_cerr   <= 1'b1;
            else                          r_credit <= r_credit + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop   <= '0;
            r_odata  <= NULL_FLIT;
            r_ovalid <= 1'b0;
        end else begin
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
            r_ovalid <= w_pop;
            if (w_pop) r_odata <= w_rdata;
        end
    end

    assign out_data   = r_odata;
    assign out_valid  = r_ovalid;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign drop_count = r_drop;
    assign credit_err = r_cerr;
endmodule

// File: tb/tb_ni_inject_buf.sv
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_ni_inject_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        credit_in = 1'b0;
    logic [19:0] out_data;
    logic        out_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  drop_count;
    logic        credit_err;

    int n_chk = 0;
    int n_err = 0;

    ni_inject_buf #(.FIFO_DEPTH(8), .CREDITS(4), .DROP_NULL(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .credit_in(credit_in), .out_data(out_data), .out_valid(out_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .drop_count(drop_count), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [19:0] m_q[$];
    int          m_cred;
    int          m_drop;
    bit          m_err;
    logic [19:0] m_od;
    bit          m_ov;
    int          ov_seen;
    logic [19:0] last_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cred = 4; m_drop = 0; m_err = 0; m_od = '0; m_ov = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ov"},    32'(out_valid),  32'(m_ov));
        chk({tag, ".od"},    32'(out_data),   32'(m_od));
        chk({tag, ".full"},  32'(fifo_full),  32'(m_q.size() == 8));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(m_q.size() == 0));
        chk({tag, ".drop"},  32'(drop_count), 32'(m_drop));
        chk({tag, ".cerr"},  32'(credit_err), 32'(m_err));
    endtask

    // One clock: drive inputs, advance the model by the cycle rules, check.
    task automatic cyc(input logic [19:0] d, input logic v, input logic c);
        int  sz;
        bit  pop, live;
        in_data = d; in_valid = v; credit_in = c;
        sz   = m_q.size();
        pop  = (sz > 0) && (m_cred > 0);
        live = v && (d != 20'h0);
        @(posedge clk);
        if (pop) begin m_od = m_q.pop_front(); m_ov = 1; end
        else m_ov = 0;
        if (live && (sz < 8 || pop)) m_q.push_back(d);
        else if (live && m_drop < 255) m_drop++;
        if (pop && !c)       m_cred--;
        else if (!pop && c) begin
            if (m_cred == 4) m_err = 1;
            else m_cred++;
        end
        #1;
        if (out_valid) begin ov_seen++; last_out = out_data; end
        chk_all("cyc");
        in_valid = 0; credit_in = 0;
    endtask

    task automatic do_reset();
        in_valid = 0; credit_in = 0;
        #1 rst = 0;
        #1;
        model_reset();
        chk_all("rst_low");
        @(posedge clk); #1;
        chk_all("rst_hold");
        rst = 1;
    endtask

    logic [19:0] exp_seq[$];
    logic [19:0] got_seq[$];

    initial begin
        model_reset();
        #2;
        chk_all("por");
        @(posedge clk); #1;
        rst = 1;

        // Idle filter
        ov_seen = 0;
        cyc(20'h00000, 1, 0); cyc(20'h10010, 1, 0);
        cyc(20'h00000, 1, 0); cyc(20'h10020, 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("idle.count", 32'(ov_seen), 32'd2);
        chk("idle.last",  32'(last_out), 32'h10020);
        chk("idle.drop",  32'(drop_count), 32'd0);

        // Credit stall
        do_reset();
        ov_seen = 0;
        for (int i = 1; i <= 6; i++) cyc(20'hA0000 + 20'(i), 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("stall.count", 32'(ov_seen), 32'd4);
        chk("stall.empty", 32'(fifo_empty), 32'd0);
        cyc(0, 0, 1);
        chk("stall.wait", 32'(out_valid), 32'd0);
        cyc(0, 0, 0);
        chk("stall.ov5", 32'(out_valid), 32'd1);
        chk("stall.d5",  32'(out_data),  32'hA0005);

        // Overflow, then full push+pop+credit in one cycle, then drain
        do_reset();
        for (int i = 0; i < 4; i++) cyc(20'hC0000 + 20'(i), 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(20'hB0000 + 20'(i), 1, 0);
        chk("ovf.full", 32'(fifo_full), 32'd1);
        chk("ovf.drop", 32'(drop_count), 32'd2);
        cyc(0, 0, 1);
        cyc(20'hD0001, 1, 1);
        chk("both.full", 32'(fifo_full), 32'd1);
        chk("both.drop", 32'(drop_count), 32'd2);
        chk("both.od",   32'(out_data), 32'hB0000);
        exp_seq.delete(); got_seq.delete();
        for (int i = 1; i < 8; i++) exp_seq.push_back(20'hB0000 + 20'(i));
        exp_seq.push_back(20'hD0001);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1);
            if (out_valid) got_seq.push_back(out_data);
        end
        chk("drain.n", 32'(got_seq.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < got_seq.size(); i++)
            chk("drain.ord", 32'(got_seq[i]), 32'(exp_seq[i]));

        // Credit overflow
        do_reset();
        cyc(0, 0, 1);
        chk("cerr.set", 32'(credit_err), 32'd1);
        cyc(20'h00123, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("cerr.sticky", 32'(credit_err), 32'd1);

        // Reset mid-stream with 3 flits buffered
        do_reset();
        for (int i = 0; i < 4; i++) cyc(20'hE0000 + 20'(i), 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(20'hE1000 + 20'(i), 1, 0);
        chk("mid.buffered", 32'(fifo_empty), 32'd0);
        do_reset();
        chk("mid.empty", 32'(fifo_empty), 32'd1);
        cyc(20'h5A5A5, 1, 0);
        chk("mid.first_lat", 32'(out_valid), 32'd0);
        cyc(0, 0, 0);
        chk("mid.ov", 32'(out_valid), 32'd1);
        chk("mid.od", 32'(out_data), 32'h5A5A5);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [19:0] d;
            d = ($urandom_range(0, 5) == 0) ? 20'h0 : 20'($urandom);
            cyc(d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ni_inject_buf.md
NI_INJECT_BUF -- requirements
Module: ni_inject_buf

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of flit entries buffered; power of two.
REQ-002 Parameter CREDITS, default 4, initial and maximum downstream credit count.
REQ-003 Parameter DROP_NULL, default 1; when 1, an input word equal to 20'h00000 is discarded as an idle flit.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  20  flit from the injection source.
REQ-007 in_valid  input  1  in_data valid this cycle; the source has no backpressure.
REQ-008 credit_in  input  1  one-cycle pulse from the router returning one buffer credit.
REQ-009 out_data  output  20  registered flit to the router input port.
REQ-010 out_valid  output  1  out_data valid this cycle; one-cycle pulse per flit.
REQ-011 fifo_full  output  1  occupancy == FIFO_DEPTH.
REQ-012 fifo_empty  output  1  occupancy == 0.
REQ-013 drop_count  output  8  saturating count of flits lost to overflow.
REQ-014 credit_err  output  1  sticky flag: credit returned while the credit count was already at CREDITS.

Function
REQ-015 Push condition: in_valid high, word not null-filtered (REQ-003), and (occupancy < FIFO_DEPTH or a pop occurs in the same cycle).
REQ-016 A null-filtered word shall neither be stored nor counted in drop_count.
REQ-017 in_valid high with a non-null word, FIFO full and no same-cycle pop: discard the word; drop_count += 1, saturating at 255.
REQ-018 Pop condition: occupancy > 0 and credit count > 0.
REQ-019 On pop: head entry loads out_data and out_valid = 1 on the next edge; credit count -= 1.
REQ-020 When no pop occurs, out_valid = 0 and out_data holds its last value.
REQ-021 Latency: a word sampled at edge k into an empty FIFO with credit > 0 appears on out_data with out_valid high after edge k+1. No bypass path exists.
REQ-022 Ordering: flits leave in strict arrival order; none are duplicated.
REQ-023 credit_in pulse: credit count += 1.
REQ-024 Simultaneous pop and credit_in: credit count unchanged.
REQ-025 credit_in with credit count == CREDITS and no same-cycle pop: count stays at CREDITS; credit_err set to 1 until reset.
REQ-026 Simultaneous push and pop: occupancy unchanged. When the FIFO is full, the incoming word is stored in the slot freed by the pop.
REQ-027 Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Occupancy is log2(FIFO_DEPTH)+1 bits wide.
REQ-028 Credit count width is clog2(CREDITS+1) bits; it shall never underflow or exceed CREDITS.
REQ-029 fifo_full and fifo_empty are decoded from registered occupancy, not from next-state values.

Reset
REQ-030 While rst is low: out_data = 20'h00000, out_valid = 0, occupancy = 0, pointers = 0, credit count = CREDITS, drop_count = 0, credit_err = 0, fifo_empty = 1, fifo_full = 0.
REQ-031 Reset asserted mid-operation discards all buffered flits; no flit is emitted in the cycle after rst releases.
REQ-032 FIFO storage contents need no reset.

Structure
REQ-033 Shared package noc_pkg holds FLIT_W = 20 and the NULL_FLIT = 20'h00000 constant; this block imports them.
REQ-034 Storage shall be one sub-module, flit_fifo, a synchronous FIFO. Its ports are push, pop, wdata, rdata, full, empty and count.
REQ-035 Credit counter, null filter, drop counter and output register reside in ni_inject_buf.

Verification
REQ-036 Idle filter: inputs 00000, 10010, 00000, 10020, each with in_valid, CREDITS = 4 -> out_valid exactly twice, out_data 10010 then 10020; drop_count = 0.
REQ-037 Credit stall: inject 6 non-null flits with no credit_in -> 4 flits out; occupancy 2; fifo_empty = 0. Then one credit_in pulse -> 5th flit out 2 cycles later.
REQ-038 Overflow: credit_in held low after 4 flits sent, then 10 more flits injected -> fifo_full = 1 after 8 of them; drop_count = 2; the surviving 8 flits drain in order once credits return.
REQ-039 Full with simultaneous push/pop and credit_in in the same cycle -> no drop; occupancy stays 8; credit count unchanged.
REQ-040 Credit overflow: credit_in pulse at reset with credit count = 4 -> credit_err = 1; it stays 1 until rst is low.
REQ-041 Reset mid-stream with 3 flits buffered -> all outputs at reset values (REQ-030); first post-reset flit is emitted 2 edges after it is sampled.
